i_fetch: RTL and testbench
==========================

Name: i_fetch

Overview:
Instruction-fetch stage; the producer side of the IF/ID interface that i_decode consumes.
- Owns the PC and drives the instruction-memory read handshake.
- Absorbs back-pressure from the hazard unit with a one-entry hold buffer.
- Squashes wrong-path fetches on branch redirect.
- Delivers a registered IF_ID_stage_t (pc, ir.word, rvfi_d) plus a valid flag to the IF/ID buffer.

Parameters:
PC_RESET, 32'h4000_0060, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction word driven in bubbles (addi x0,x0,0).

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  reset, asynchronous, active-high.
stall  in  1  hazard-unit back-pressure; the decoder cannot accept this cycle.
branch_take  in  1  redirect from EX; same signal that zeroes the decoder control word.
branch_target  in  32  redirect PC, valid when branch_take=1.
imem_address  out  32  fetch address; held stable while imem_read=1.
imem_read  out  1  read request; held until imem_resp.
imem_rdata  in  32  instruction word, valid when imem_resp=1.
imem_resp  in  1  one-cycle response pulse.
if_out  out  IF_ID_stage_t  registered pc, ir.word and rvfi_d fields.
if_valid  out  1  if_out holds a real instruction.

Behaviour:
Reset (async, rst=1):
- pc=PC_RESET, req_addr=PC_RESET, state=FETCH.
- if_valid=0, if_out.pc=PC_RESET, if_out.ir.word=NOP_INSTR, if_out.rvfi_d='0.
- order counter=0, hold buffer invalid.
- While rst=1, imem_read=0; it asserts in the first cycle after release.
- Reset mid-request abandons the transaction; any late imem_resp is ignored.

Priority per cycle: rst > branch_take > stall > imem_resp.

States:
- FETCH: imem_read=1, imem_address=req_addr=pc.
  - On imem_resp with no branch_take, and stall=0: load if_out next edge (pc=req_addr, ir=imem_rdata); set if_valid=1; pc=req_addr+4; stay in FETCH.
  - On imem_resp with no branch_take, and stall=1: capture {req_addr, imem_rdata} into the hold buffer; pc=req_addr+4; go to HOLD. if_out is unchanged.
  - On branch_take without imem_resp: pc=branch_target; go to SQUASH. imem_address stays at the old req_addr.
  - On branch_take together with imem_resp: discard rdata; pc=req_addr=branch_target; stay in FETCH. The next request goes to the target the following cycle.
- SQUASH: imem_read=1 at the old req_addr until imem_resp; the response is discarded.
  - Then req_addr=pc; go to FETCH.
  - Further branch_take in SQUASH overwrites pc (last target wins).
- HOLD: imem_read=0.
  - When stall=0: move the buffer to if_out with if_valid=1; go to FETCH.
  - branch_take in HOLD: drop the buffer; pc=req_addr=branch_target; go to FETCH.

Output register rules:
- stall=1 and no branch_take: if_out and if_valid are frozen.
- branch_take=1: if_valid=0 and ir.word=NOP_INSTR next edge, whether or not stall=1.
- stall=0 and no instruction available: bubble (if_valid=0, ir=NOP_INSTR, pc unchanged).

RVFI and arithmetic:
- On a valid load: rvfi_d.rvfi_pc_rdata=pc, rvfi_d.rvfi_pc_wdata=pc+4, rvfi_d.rvfi_order=order counter. The counter then increments. Squashed or discarded words never consume an order number.
- PC arithmetic is 32-bit modulo, so 0xFFFF_FFFC+4 wraps to 0.
- branch_target is used unmodified; no alignment checking.

Latency: a word appears on if_out the edge after imem_resp. Throughput is one instruction per memory response.

Decomposition:
- rv32i_types gains:
  - fetch_state_t enum {FETCH, SQUASH, HOLD};
  - the PC_RESET and NOP_INSTR defaults as localparams.
- IF_ID_stage_t is unchanged and shared with i_decode.
- One sub-module, fetch_hold_buf: one-entry {pc, word} register with set/clear/valid, asynchronous active-high reset.

Test Plan:
1. Reset release, imem_resp latency 1, words 0x00A00093 then 0x00108113, no stall.
   - imem_address steps 0x40000060, 0x40000064.
   - if_out.pc = 0x40000060/0x40000064 with if_valid=1; rvfi_order 0,1.
2. Memory latency 3 cycles.
   - imem_read and imem_address stay stable for 3 cycles.
   - if_valid=0 with ir=0x00000013 in the gap cycles.
3. stall=1 asserted when imem_resp arrives at 0x40000068, held 4 cycles.
   - if_out frozen, imem_read=0 in HOLD.
   - After release, if_out.pc=0x40000068; next request goes to 0x4000006C.
4. branch_take with target 0x40000100 while a request to 0x40000070 is outstanding.
   - The 0x40000070 response is discarded.
   - Next imem_address=0x40000100, if_valid=0 meanwhile, no order increment.
5. branch_take coincident with imem_resp, and separately with HOLD occupied.
   - Both cases drop the word; the next fetch is at the target, no order consumed.
6. Assert rst mid-request, then pulse a stale imem_resp.
   - Outputs return to reset values immediately (asynchronous).
   - The stale response is ignored; the first fetch after release is at 0x40000060.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types and defaults used by the fetch and decode stages.
// IF_ID_stage_t is the IF/ID hand-off record consumed by i_decode.
package rv32i_types;

  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h4000_0060;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    SQUASH,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] word;
  } instr_t;

  typedef struct packed {
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata;
  } rvfi_d_t;

  typedef struct packed {
    logic [31:0] pc;
    instr_t      ir;
    rvfi_d_t     rvfi_d;
  } IF_ID_stage_t;

  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/i_fetch_hold_buf.sv
// One-entry {pc, word} buffer that parks a fetched instruction while decode
// is stalled. Set wins over clear when both are asserted.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_set,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_word,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_word
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_word  <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_word  <= i_word;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_word  = r_word;

endmodule

// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem read handshake, parks a
// word across decode stalls and squashes wrong-path fetches on redirect.
module i_fetch
  import rv32i_types::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_take,
  input  logic [31:0]  branch_target,
  output logic [31:0]  imem_address,
  output logic         imem_read,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_resp,
  output IF_ID_stage_t if_out,
  output logic         if_valid
);

  fetch_state_t r_state;
  fetch_state_t w_nextState;
  logic [31:0]  r_pc;
  logic [31:0]  r_reqAddr;
  logic [31:0]  w_nextPc;
  logic [31:0]  w_nextReqAddr;
  logic [63:0]  r_order;
  IF_ID_stage_t r_ifOut;
  logic         r_ifValid;
  logic         w_load;
  logic         w_holdSet;
  logic         w_holdClear;
  logic         w_holdValid;
  logic [31:0]  w_holdPc;
  logic [31:0]  w_holdWord;
  logic [31:0]  w_loadPc;
  logic [31:0]  w_loadWord;

  fetch_hold_buf u_holdBuf (
    .clk    (clk),
    .rst    (rst),
    .i_set  (w_holdSet),
    .i_clear(w_holdClear),
    .i_pc   (r_reqAddr),
    .i_word (imem_rdata),
    .o_valid(w_holdValid),
    .o_pc   (w_holdPc),
    .o_word (w_holdWord)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH: begin
        if (branch_take)          w_nextState = imem_resp ? FETCH : SQUASH;
        else if (imem_resp && stall) w_nextState = HOLD;
      end
      SQUASH:  if (imem_resp) w_nextState = FETCH;
      HOLD:    if (branch_take || !stall) w_nextState = FETCH;
      default: w_nextState = FETCH;
    endcase
  end

  // A squashed request keeps its old address on the bus until memory answers;
  // only then does the request address catch up with the redirected PC.
  always_comb begin
    imem_read     = 1'b0;
    imem_address  = r_reqAddr;
    w_load        = 1'b0;
    w_holdSet     = 1'b0;
    w_holdClear   = 1'b0;
    w_loadPc      = r_reqAddr;
    w_loadWord    = imem_rdata;
    w_nextPc      = r_pc;
    w_nextReqAddr = r_reqAddr;
    case (r_state)
      FETCH: begin
        imem_read = !rst;
        if (branch_take) begin
          w_nextPc = branch_target;
          if (imem_resp) w_nextReqAddr = branch_target;
        end else if (imem_resp) begin
          w_nextPc      = pcPlus4(r_reqAddr);
          w_nextReqAddr = pcPlus4(r_reqAddr);
          w_holdSet     = stall;
          w_load        = !stall;
        end
      end
      SQUASH: begin
        imem_read = !rst;
        if (branch_take) w_nextPc = branch_target;
        if (imem_resp)   w_nextReqAddr = branch_take ? branch_target : r_pc;
      end
      HOLD: begin
        w_loadPc   = w_holdPc;
        w_loadWord = w_holdWord;
        if (branch_take) begin
          w_nextPc      = branch_target;
          w_nextReqAddr = branch_target;
          w_holdClear   = 1'b1;
        end else if (!stall) begin
          w_load      = w_holdValid;
          w_holdClear = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc             <= PC_RESET;
      r_reqAddr        <= PC_RESET;
      r_order          <= '0;
      r_ifValid        <= 1'b0;
      r_ifOut.pc       <= PC_RESET;
      r_ifOut.ir.word  <= NOP_INSTR;
      r_ifOut.rvfi_d   <= '0;
    end else begin
      r_pc      <= w_nextPc;
      r_reqAddr <= w_nextReqAddr;
      if (branch_take) begin
        r_ifValid       <= 1'b0;
        r_ifOut.ir.word <= NOP_INSTR;
      end else if (!stall) begin
        if (w_load) begin
          r_ifValid                      <= 1'b1;
          r_ifOut.pc                     <= w_loadPc;
          r_ifOut.ir.word                <= w_loadWord;
          r_ifOut.rvfi_d.rvfi_pc_rdata   <= w_loadPc;
          r_ifOut.rvfi_d.rvfi_pc_wdata   <= pcPlus4(w_loadPc);
          r_ifOut.rvfi_d.rvfi_order      <= r_order;
          r_order                        <= r_order + 64'd1;
        end else begin
          r_ifValid       <= 1'b0;
          r_ifOut.ir.word <= NOP_INSTR;
        end
      end
    end
  end

  assign if_out   = r_ifOut;
  assign if_valid = r_ifValid;

endmodule

// File: tb/tb_i_fetch.sv
// Randomised scoreboard bench for i_fetch: a transaction-level model predicts
// the delivered instruction stream, and a negedge monitor compares each new word.
module tb_i_fetch;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h4000_0060;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         branch_take;
  logic [31:0]  branch_target;
  logic [31:0]  imem_address;
  logic         imem_read;
  logic [31:0]  imem_rdata;
  logic         imem_resp;
  IF_ID_stage_t if_out;
  logic         if_valid;

  i_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_take  (branch_take),
    .branch_target(branch_target),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .if_out       (if_out),
    .if_valid     (if_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  IF_ID_stage_t expQ[$];
  logic monEnable = 1'b0;
  logic prevValid = 1'b0;

  // Architectural view: next address to fetch, whether the in-flight request
  // is wrong-path, a parked word, and how many words have been delivered.
  logic [31:0]     fetchAddr;
  logic            stale;
  logic            haveHeld;
  logic [31:0]     heldPc;
  logic [31:0]     heldWord;
  longint unsigned order;
  int              latLeft;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic deliver(input logic [31:0] pc, input logic [31:0] word);
    IF_ID_stage_t e;
    e.pc                   = pc;
    e.ir.word              = word;
    e.rvfi_d.rvfi_pc_rdata = pc;
    e.rvfi_d.rvfi_pc_wdata = pc + 32'd4;
    e.rvfi_d.rvfi_order    = order;
    order++;
    expQ.push_back(e);
  endtask

  task automatic resetModel();
    fetchAddr = RESET_PC;
    stale     = 1'b0;
    haveHeld  = 1'b0;
    heldPc    = '0;
    heldWord  = '0;
    order     = 0;
    latLeft   = $urandom_range(0, 3);
    expQ.delete();
  endtask

  always @(negedge clk) begin
    if (monEnable) begin
      if (if_valid === 1'b1 && (!prevValid || !stall)) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got pc %h word %h expected nothing", if_out.pc, if_out.ir.word);
        end else begin
          checkOutput("if_out_word", if_out, expQ.pop_front());
        end
      end else if (if_valid === 1'b0) begin
        checkOutput("bubble_ir", {160'd0, if_out.ir.word}, {160'd0, NOP});
      end
      prevValid = if_valid;
    end else begin
      prevValid = 1'b0;
    end
  end

  task automatic applyStimulus(input int cycles, input bit randomOn);
    for (int i = 0; i < cycles; i++) begin
      logic        br;
      logic        st;
      logic        rs;
      logic [31:0] tgt;
      @(negedge clk);
      #1;
      checkOutput("imem_read", {191'd0, imem_read}, {191'd0, !haveHeld});
      if (imem_read && !stale)
        checkOutput("imem_address", {160'd0, imem_address}, {160'd0, fetchAddr});
      br = randomOn && ($urandom_range(0, 9) == 0);
      st = randomOn && ($urandom_range(0, 9) < 3);
      rs = 1'b0;
      if (randomOn && imem_read) begin
        if (latLeft == 0) begin
          rs      = 1'b1;
          latLeft = $urandom_range(0, 3);
        end else begin
          latLeft--;
        end
      end
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                         : (32'h4000_0000 | 32'($urandom_range(0, 1023) << 2));
      branch_take   = br;
      branch_target = tgt;
      stall         = st;
      imem_resp     = rs;
      imem_rdata    = rs ? memWord(imem_address) : $urandom();
      if (br) begin
        stale     = !haveHeld && !rs;
        haveHeld  = 1'b0;
        fetchAddr = tgt;
      end else if (rs) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          if (st) begin
            haveHeld = 1'b1;
            heldPc   = fetchAddr;
            heldWord = memWord(fetchAddr);
          end else begin
            deliver(fetchAddr, memWord(fetchAddr));
          end
          fetchAddr = fetchAddr + 32'd4;
        end
      end else if (haveHeld && !st) begin
        deliver(heldPc, heldWord);
        haveHeld = 1'b0;
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    branch_take   = 1'b0;
    branch_target = '0;
    imem_resp     = 1'b0;
    imem_rdata    = '0;
    resetModel();
    #12;
    checkOutput("reset_if_out", if_out, {RESET_PC, NOP, 128'd0});
    checkOutput("reset_if_valid", {191'd0, if_valid}, 192'd0);
    checkOutput("reset_imem_read", {191'd0, imem_read}, 192'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    resetModel();
    #1;
    checkOutput("release_imem_read", {191'd0, imem_read}, {191'd0, 1'b1});
    checkOutput("release_imem_address", {160'd0, imem_address}, {160'd0, RESET_PC});
    monEnable = 1'b1;
    applyStimulus(3000, 1'b1);
    applyStimulus(6, 1'b0);
    checkOutput("queue_drained_1", 192'(expQ.size()), 192'd0);

    // Reset in the middle of an outstanding request, then a stale response.
    @(negedge clk);
    #2;
    monEnable = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midreset_if_out", if_out, {RESET_PC, NOP, 128'd0});
    checkOutput("midreset_if_valid", {191'd0, if_valid}, 192'd0);
    checkOutput("midreset_imem_read", {191'd0, imem_read}, 192'd0);
    @(negedge clk);
    #1;
    imem_resp  = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    imem_resp = 1'b0;
    checkOutput("stale_resp_if_valid", {191'd0, if_valid}, 192'd0);
    checkOutput("stale_resp_if_out", if_out, {RESET_PC, NOP, 128'd0});
    rst = 1'b0;
    resetModel();
    #1;
    checkOutput("rerelease_imem_read", {191'd0, imem_read}, {191'd0, 1'b1});
    checkOutput("rerelease_imem_address", {160'd0, imem_address}, {160'd0, RESET_PC});
    monEnable = 1'b1;
    applyStimulus(1500, 1'b1);
    applyStimulus(6, 1'b0);
    checkOutput("queue_drained_2", 192'(expQ.size()), 192'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
